dmem_lsu_sched: RTL

- Schedules the out-of-order core's data-memory traffic onto the dmem port group: dmem_addressLoad/dmem_readEn, dmem_addressStore/dmem_WriteData/dmem_writeEn, dmem_readData.
- Holds committed stores from the ROB in an in-order store buffer (SB) and drains one store per cycle to the write port.
- Issues speculative loads to the read port in the same cycle, holding a load off while it aliases a pending store.
- Supports a fence that drains the SB before any further loads; sits between the LSQ/ROB commit logic and datamem.

---
 rtl/dmem_lsu_pkg.sv | 24 ++
 rtl/dmem_lsu_sched_sb_fifo.sv | 82 ++++++++
 rtl/dmem_lsu_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared types and constants for the dmem load/store scheduler
package dmem_lsu_pkg;

  localparam int WORD_LSB  = 3;
  localparam int SB_ADDR_W = 64;
  localparam int SB_DATA_W = 64;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FENCE  = 1'b1
  } state_t;

  // Aliasing is decided on 8-byte words, so the low address bits are ignored.
  function automatic logic same_word(input logic [SB_ADDR_W-1:0] a,
                                     input logic [SB_ADDR_W-1:0] b);
    return a[SB_ADDR_W-1:WORD_LSB] == b[SB_ADDR_W-1:WORD_LSB];
  endfunction

endpackage

// File: rtl/dmem_lsu_sched_sb_fifo.sv
// rtl/dmem_lsu_sched_sb_fifo.sv - in-order store buffer with parallel word-alias compare
// SB_FWD_EN adds a youngest-matching-entry data output for store-to-load forwarding.
module sb_fifo
  import dmem_lsu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  sb_entry_t            push_entry,
  input  logic                 pop,
  input  logic [SB_ADDR_W-1:0] cmp_addr,
  output sb_entry_t            head,
  output logic [CNT_W-1:0]     count,
  output logic                 hit
`ifdef SB_FWD_EN
  ,
  output logic [SB_DATA_W-1:0] match_data
`endif
);

  sb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_scan_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      if (pop)  r_head <= r_head + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_tail] <= push_entry;
  end

  assign head  = r_mem[r_head];
  assign count = r_count;

  always_comb begin
    hit        = 1'b0;
    w_scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count && same_word(r_mem[w_scan_idx].addr, cmp_addr)) hit = 1'b1;
    end
  end

`ifdef SB_FWD_EN
  logic [PTR_W-1:0] w_match_idx;
  logic [PTR_W-1:0] w_fwd_scan;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    w_match_idx = '0;
    w_fwd_scan  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fwd_scan = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count && same_word(r_mem[w_fwd_scan].addr, cmp_addr))
        w_match_idx = w_fwd_scan;
    end
  end

  assign match_data = r_mem[w_match_idx].data;
`endif

endmodule

// File: rtl/dmem_lsu_sched.sv
// rtl/dmem_lsu_sched.sv - schedules committed stores and speculative loads onto the dmem ports
// Optional store-to-load forwarding under SB_FWD_EN; ADDR_W must not exceed 64.
module dmem_lsu_sched
  import dmem_lsu_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int TAG_W    = 3,
  parameter int ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [TAG_W-1:0]  ld_tag_i,
  output logic              ld_resp_valid_o,
  output logic [63:0]       ld_resp_data_o,
  output logic [TAG_W-1:0]  ld_resp_tag_o,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [63:0]       st_data_i,
  input  logic              flush_i,
  input  logic              fence_i,
  output logic              fence_done_o,
  output logic              sb_empty_o,
  input  logic [63:0]       dmem_readData,
  output logic [ADDR_W-1:0] dmem_addressLoad,
  output logic              dmem_readEn,
  output logic [ADDR_W-1:0] dmem_addressStore,
  output logic [63:0]       dmem_WriteData,
  output logic              dmem_writeEn
);

  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ld_addr;
  logic              r_resp_valid;
  logic [TAG_W-1:0]  r_resp_tag;

  sb_entry_t         w_push_entry;
  sb_entry_t         w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_hit;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_acc;
  logic              w_rd_acc;

  assign w_push_entry.addr = SB_ADDR_W'(st_addr_i);
  assign w_push_entry.data = st_data_i;

  assign st_ready_o = w_count < CNT_W'(SB_DEPTH);
  assign w_push     = st_valid_i && st_ready_o;
  assign w_pop      = w_count != '0;
  assign sb_empty_o = w_count == '0;

`ifdef SB_FWD_EN
  logic [63:0] w_match_data;
  logic        r_resp_fwd;
  logic [63:0] r_fwd_data;
`endif

  sb_fifo #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .cmp_addr   (SB_ADDR_W'(ld_addr_i)),
    .head       (w_head),
    .count      (w_count),
    .hit        (w_hit)
`ifdef SB_FWD_EN
    ,
    .match_data (w_match_data)
`endif
  );

  assign dmem_writeEn      = w_pop;
  assign dmem_addressStore = w_pop ? ADDR_W'(w_head.addr) : '0;
  assign dmem_WriteData    = w_pop ? w_head.data : '0;

`ifdef SB_FWD_EN
  assign ld_ready_o = (r_state == NORMAL);
`else
  // A hit includes the head being drained this cycle, so the load retries after the pop.
  assign ld_ready_o = (r_state == NORMAL) && !w_hit;
`endif

  assign w_ld_acc         = ld_valid_i && ld_ready_o;
  assign w_rd_acc         = w_ld_acc && !w_hit;
  assign dmem_readEn      = w_rd_acc;
  assign dmem_addressLoad = w_rd_acc ? ld_addr_i : r_ld_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= NORMAL;
      r_ld_addr    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_tag   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_valid <= w_ld_acc && !flush_i;
      if (w_ld_acc) r_resp_tag <= ld_tag_i;
      if (w_rd_acc) r_ld_addr  <= ld_addr_i;
    end
  end

`ifdef SB_FWD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_fwd <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_resp_fwd <= w_ld_acc && w_hit;
      if (w_ld_acc && w_hit) r_fwd_data <= w_match_data;
    end
  end

  assign ld_resp_data_o = !r_resp_valid ? '0 : (r_resp_fwd ? r_fwd_data : dmem_readData);
`else
  assign ld_resp_data_o = r_resp_valid ? dmem_readData : '0;
`endif

  assign ld_resp_valid_o = r_resp_valid;
  assign ld_resp_tag_o   = r_resp_tag;

  always_comb begin
    w_state_nxt  = r_state;
    fence_done_o = 1'b0;
    case (r_state)
      NORMAL: if (fence_i) w_state_nxt = FENCE;
      FENCE: begin
        if (w_count == '0 && !w_push) begin
          w_state_nxt  = NORMAL;
          fence_done_o = 1'b1;
        end
      end
      default: w_state_nxt = NORMAL;
    endcase
  end

endmodule
